reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   Architectural register file: the consumer end of the write-back interface.
//   Absorbs the WB stage's (RegWrite, Rd, WB_Data) stream and serves two
//   combinational read ports to decode.
//   Per-register pending-write scoreboard: decode marks a destination at issue
//   and WB retires it; busy flags drive the hazard/stall logic.
// PARAMETERS
//   DATA_W  32  register width
//   ADDR_W  5   register index width; NREGS = 2**ADDR_W
//   PEND_W  2   per-register pending counter width (max 2**PEND_W-1 outstanding)
// PORTS
//   clk       in   1       clock, all state on posedge
//   rst       in   1       asynchronous, active-high reset
//   wb_we     in   1       write enable from WB stage (ResW_out)
//   wb_rd     in   ADDR_W  write-back destination (Rd4)
//   wb_data   in   DATA_W  write-back value (WB_Data)
//   iss_valid in   1       decode issues an instr that will write iss_rd
//   iss_rd    in   ADDR_W  destination of issued instr
//   rs1_addr  in   ADDR_W  read port 1 index
//   rs2_addr  in   ADDR_W  read port 2 index
//   rs1_data  out  DATA_W  read port 1 data (combinational)
//   rs2_data  out  DATA_W  read port 2 data (combinational)
//   rs1_busy  out  1       pending write outstanding on rs1_addr
//   rs2_busy  out  1       pending write outstanding on rs2_addr
//   sb_err    out  1       sticky scoreboard error (overflow/underflow)
// BEHAVIOUR
//   - Reset (async, immediate): all registers 0, all pending counters 0,
//     sb_err 0. Outputs therefore read 0 / busy 0 during and after reset.
//   - Register 0: always reads 0; writes to r0 discarded; issue/WB targeting
//     r0 never touch its counter, never flag sb_err, rs*_busy=0 for r0.
//   - Write: posedge with wb_we=1, wb_rd!=0 -> regs[wb_rd] <= wb_data.
//     Visible on read ports the cycle after (without bypass).
//   - Read: rsN_data = regs[rsN_addr], zero latency; both ports independent,
//     same address on both ports legal.
//   - Scoreboard per reg: cnt +1 on iss_valid (iss_rd), -1 on wb_we (wb_rd).
//     Both same reg same cycle -> cnt unchanged. rsN_busy = (cnt[rsN_addr]!=0).
//   - Overflow: iss_valid to reg with cnt=max -> cnt holds, sb_err<=1.
//   - Underflow: wb_we to reg with cnt=0 -> data still written, cnt stays 0,
//     sb_err<=1.
//   - sb_err sticky until rst; no other effect on operation.
//   - Reset mid-operation clears all state; in-flight WB after reset is
//     treated as underflow if cnt=0.
// CONFIGURATION
//   WB_BYPASS_EN defined: write-through. If wb_we && wb_rd==rsN_addr && !=0,
//     rsN_data=wb_data same cycle, and rsN_busy is deasserted that cycle when
//     cnt==1 (the retiring write satisfies the read).
//   WB_BYPASS_EN undefined: read returns old value; busy stays set until the
//     counter decrements at the edge (one extra stall cycle in decode).
// STRUCTURE
//   reg_file_pkg: DATA_W, ADDR_W, PEND_W, ZERO_REG=0, PEND_MAX localparam.
//   Sub-module pend_ctr (one PEND_W up/down counter with inc, dec, busy,
//   ovf, unf outputs), generated NREGS-1 times (r1..rN); reg_file owns the
//   array, read muxes, bypass and sb_err OR-reduction.
// TESTING
//   1. rst=1 then 0; read r0..r31 -> all 0, busy 0, sb_err 0.
//   2. iss r10; next cycle rs1=r10 -> busy=1; wb_we r10=32'hA5A5A5A5 ->
//      following cycle rs1_data=A5A5A5A5, busy=0, sb_err=0.
//   3. Same-cycle wb r10=32'h95632214 and rs1=r10: with WB_BYPASS_EN data=
//      95632214 same cycle; without, old value then 95632214 next cycle.
//   4. wb_we r0=32'hFFFFFFFF; iss r0 -> rs1=r0 reads 0, busy 0, sb_err 0.
//   5. iss r5 four times (PEND_W=2) -> 4th sets sb_err; three wb_we r5 ->
//      busy clears; a 4th wb_we r5 writes data, sb_err stays 1.
//   6. iss r7 and wb r7 same cycle with cnt=1 -> cnt stays 1, busy stays 1;
//      assert rst mid-stream -> busy 0, data 0 immediately (async).

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared sizing constants for the architectural register file and its
// per-register pending-write scoreboard.
package reg_file_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned PEND_W = 2;
    localparam int unsigned NREGS  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

endpackage

// File: rtl/reg_file_pend_ctr.sv
// Saturating pending-write counter for one architectural register: +1 on issue,
// -1 on write-back, with overflow/underflow strobes for the sticky error flag.
module reg_file_pend_ctr
    import reg_file_pkg::*;
#(
    parameter bit Bypass = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_busy,
    output logic o_ovf,
    output logic o_unf
);

    logic [PEND_W-1:0] r_cnt;
    logic              w_at_max;
    logic              w_at_zero;
    logic              w_up;
    logic              w_down;

    assign w_at_max  = (r_cnt == PEND_MAX);
    assign w_at_zero = (r_cnt == '0);

    // Simultaneous issue and retire cancel out and are never an error.
    assign w_up   = i_inc && !i_dec;
    assign w_down = i_dec && !i_inc;

    assign o_ovf = w_up && w_at_max;
    assign o_unf = w_down && w_at_zero;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_up && !w_at_max) begin
            r_cnt <= r_cnt + PEND_ONE;
        end else if (w_down && !w_at_zero) begin
            r_cnt <= r_cnt - PEND_ONE;
        end
    end

    // With write-through, the last retiring write already satisfies a reader.
    always_comb begin
        if (Bypass) begin
            o_busy = !w_at_zero && !(i_dec && (r_cnt == PEND_ONE));
        end else begin
            o_busy = !w_at_zero;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with two combinational read ports and a
// per-register pending-write scoreboard. Define WB_BYPASS_EN for write-through.
module reg_file
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              sb_err
);

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  w_busy;
    logic [NREGS-1:0]  w_ovf;
    logic [NREGS-1:0]  w_unf;
    logic              r_sb_err;
    logic [DATA_W-1:0] w_rs1_reg;
    logic [DATA_W-1:0] w_rs2_reg;
    logic              w_hit1;
    logic              w_hit2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we && (wb_rd != ZERO_REG)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // r0 has no counter: it can never be busy or raise an error.
    assign w_busy[0] = 1'b0;
    assign w_ovf[0]  = 1'b0;
    assign w_unf[0]  = 1'b0;

    for (genvar g = 1; g < NREGS; g++) begin : g_pend
        logic w_inc;
        logic w_dec;

        assign w_inc = iss_valid && (iss_rd == ADDR_W'(g));
        assign w_dec = wb_we && (wb_rd == ADDR_W'(g));

        reg_file_pend_ctr #(
            .Bypass (BYPASS)
        ) u_pend_ctr (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_inc  (w_inc),
            .i_dec  (w_dec),
            .o_busy (w_busy[g]),
            .o_ovf  (w_ovf[g]),
            .o_unf  (w_unf[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb_err <= 1'b0;
        end else begin
            r_sb_err <= r_sb_err | (|w_ovf) | (|w_unf);
        end
    end

    assign w_rs1_reg = (rs1_addr == ZERO_REG) ? '0 : r_regs[rs1_addr];
    assign w_rs2_reg = (rs2_addr == ZERO_REG) ? '0 : r_regs[rs2_addr];

    assign w_hit1 = BYPASS && wb_we && (wb_rd == rs1_addr) && (rs1_addr != ZERO_REG);
    assign w_hit2 = BYPASS && wb_we && (wb_rd == rs2_addr) && (rs2_addr != ZERO_REG);

    assign rs1_data = w_hit1 ? wb_data : w_rs1_reg;
    assign rs2_data = w_hit2 ? wb_data : w_rs2_reg;
    assign rs1_busy = w_busy[rs1_addr];
    assign rs2_busy = w_busy[rs2_addr];
    assign sb_err   = r_sb_err;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expectations are queued when stimulus is driven
// and popped against the DUT outputs on each sample.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        sb_err;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_file u_dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] v);
        sb_q.push_back('{tag: tag, exp: v});
    endtask

    task automatic cmp(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Drive one cycle of issue/write-back, then return just after the edge.
    task automatic op(input logic iv, input logic [4:0] ir, input logic wv,
                      input logic [4:0] wr, input logic [31:0] wd);
        iss_valid = iv;
        iss_rd    = ir;
        wb_we     = wv;
        wb_rd     = wr;
        wb_data   = wd;
        @(posedge clk);
        #1;
        iss_valid = 1'b0;
        wb_we     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        iss_valid = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: everything reads zero after reset
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            expect_val("rst_rs1_data", 32'h0); cmp(rs1_data);
            expect_val("rst_rs2_data", 32'h0); cmp(rs2_data);
            expect_val("rst_rs1_busy", 32'h0); cmp({31'h0, rs1_busy});
            expect_val("rst_rs2_busy", 32'h0); cmp({31'h0, rs2_busy});
        end
        expect_val("rst_sb_err", 32'h0); cmp({31'h0, sb_err});

        // 2: issue then retire r10
        op(1'b1, 5'd10, 1'b0, 5'd0, 32'h0);
        rs1_addr = 5'd10; #1;
        expect_val("iss_busy", 32'h1); cmp({31'h0, rs1_busy});
        op(1'b0, 5'd0, 1'b1, 5'd10, 32'hA5A5A5A5);
        #1;
        expect_val("wb_data", 32'hA5A5A5A5); cmp(rs1_data);
        expect_val("wb_busy", 32'h0); cmp({31'h0, rs1_busy});
        expect_val("wb_sb_err", 32'h0); cmp({31'h0, sb_err});

        // 3: same-cycle write-back and read
        op(1'b1, 5'd10, 1'b0, 5'd0, 32'h0);
        wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'h95632214;
        #1;
        expect_val("byp_data", BYP ? 32'h95632214 : 32'hA5A5A5A5); cmp(rs1_data);
        expect_val("byp_busy", BYP ? 32'h0 : 32'h1); cmp({31'h0, rs1_busy});
        @(posedge clk); #1;
        wb_we = 1'b0; #1;
        expect_val("post_data", 32'h95632214); cmp(rs1_data);
        expect_val("post_busy", 32'h0); cmp({31'h0, rs1_busy});

        // 4: r0 is immune to writes and issues
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_rd = 5'd0;
        #1;
        expect_val("r0_same_cycle", 32'h0); cmp(rs1_data);
        op(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        expect_val("r0_data", 32'h0); cmp(rs2_data);
        expect_val("r0_busy", 32'h0); cmp({31'h0, rs1_busy});
        expect_val("r0_sb_err", 32'h0); cmp({31'h0, sb_err});

        // 5: overflow and underflow on r5
        rs1_addr = 5'd5;
        for (int k = 0; k < 3; k++) op(1'b1, 5'd5, 1'b0, 5'd0, 32'h0);
        #1;
        expect_val("ovf3_busy", 32'h1); cmp({31'h0, rs1_busy});
        expect_val("ovf3_sb_err", 32'h0); cmp({31'h0, sb_err});
        op(1'b1, 5'd5, 1'b0, 5'd0, 32'h0);
        #1;
        expect_val("ovf4_sb_err", 32'h1); cmp({31'h0, sb_err});
        op(1'b0, 5'd0, 1'b1, 5'd5, 32'h1);
        op(1'b0, 5'd0, 1'b1, 5'd5, 32'h2);
        #1;
        expect_val("unf2_busy", 32'h1); cmp({31'h0, rs1_busy});
        op(1'b0, 5'd0, 1'b1, 5'd5, 32'h3);
        #1;
        expect_val("unf3_busy", 32'h0); cmp({31'h0, rs1_busy});
        expect_val("unf3_data", 32'h3); cmp(rs1_data);
        op(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD0005);
        #1;
        expect_val("unf4_data", 32'hDEAD0005); cmp(rs1_data);
        expect_val("unf4_busy", 32'h0); cmp({31'h0, rs1_busy});
        expect_val("unf4_sb_err", 32'h1); cmp({31'h0, sb_err});

        // 6: issue+retire same cycle, then async reset mid-stream
        rs1_addr = 5'd7; rs2_addr = 5'd5;
        op(1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
        op(1'b1, 5'd7, 1'b1, 5'd7, 32'h00000077);
        #1;
        expect_val("both_busy", 32'h1); cmp({31'h0, rs1_busy});
        expect_val("both_data", 32'h00000077); cmp(rs1_data);
        op(1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
        #1;
        expect_val("pre_rst_busy", 32'h1); cmp({31'h0, rs1_busy});
        rst = 1'b1;
        #1;
        expect_val("arst_busy", 32'h0); cmp({31'h0, rs1_busy});
        expect_val("arst_rs1_data", 32'h0); cmp(rs1_data);
        expect_val("arst_rs2_data", 32'h0); cmp(rs2_data);
        expect_val("arst_sb_err", 32'h0); cmp({31'h0, sb_err});
        @(posedge clk); #1;
        rst = 1'b0;
        op(1'b0, 5'd0, 1'b1, 5'd7, 32'hCAFE0007);
        #1;
        expect_val("late_wb_data", 32'hCAFE0007); cmp(rs1_data);
        expect_val("late_wb_sb_err", 32'h1); cmp({31'h0, sb_err});
        expect_val("late_wb_busy", 32'h0); cmp({31'h0, rs1_busy});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
